// File: rtl/reff_avg.sv
// Frame-rate post-processor: resynchronises head_flag, captures channel words once per frame,
// and keeps an N-deep moving average of reff with a deviation flag.
module reff_avg #(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned DEV_THR  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             head_flag,
  input  logic [WIDTH-1:0] buffer_2,
  input  logic [WIDTH-1:0] buffer_3,
  input  logic [WIDTH-1:0] reff,
  output logic [WIDTH-1:0] ch1_out,
  output logic [WIDTH-1:0] ch2_out,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             frame_done,
  output logic             dev_flag,
  output logic             win_full,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned N    = 1 << AVG_LOG2;
  localparam int unsigned AccW = WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FillMax = N[AVG_LOG2:0];
  localparam logic [WIDTH:0]    Thr     = (WIDTH + 1)'(DEV_THR);

  typedef enum logic [1:0] {StIdle, StUpd, StOut} state_e;

  state_e state_q, state_d;

  logic hf_s1_q, hf_s2_q, hf_s3_q;
  logic fall;
  logic cap_en, upd_en, out_en;

  logic [WIDTH-1:0]        cap_b2_q, cap_b3_q, samp_q;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [AVG_LOG2-1:0]     wr_ptr_q;
  logic [AVG_LOG2:0]       fill_cnt_q;
  logic [WIDTH-1:0]        ring_q [N];
  logic [WIDTH-1:0]        old_w;
  logic signed [WIDTH-1:0] avg_w;
  logic signed [WIDTH:0]   diff_w;
  logic [WIDTH:0]          abs_w;

  logic [WIDTH-1:0] ch1_q, ch2_q, avg_q;
  logic             avg_valid_q, frame_done_q, dev_flag_q;
  logic [15:0]      frame_cnt_q;

  assign fall     = hf_s3_q & ~hf_s2_q;
  assign win_full = (fill_cnt_q == FillMax);

  // Oldest sample only leaves the sum once the window has wrapped.
  assign old_w  = win_full ? ring_q[wr_ptr_q] : '0;
  assign acc_d  = acc_q + AccW'($signed(samp_q)) - AccW'($signed(old_w));
  assign avg_w  = WIDTH'(acc_q >>> AVG_LOG2);
  assign diff_w = (WIDTH + 1)'($signed(samp_q)) - (WIDTH + 1)'(avg_w);
  assign abs_w  = diff_w[WIDTH] ? (WIDTH + 1)'(-diff_w) : diff_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fall) state_d = StUpd;
      StUpd:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cap_en = 1'b0;
    upd_en = 1'b0;
    out_en = 1'b0;
    unique case (state_q)
      StIdle:  cap_en = fall;
      StUpd:   upd_en = 1'b1;
      StOut:   out_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hf_s1_q <= 1'b0;
      hf_s2_q <= 1'b0;
      hf_s3_q <= 1'b0;
    end else begin
      hf_s1_q <= head_flag;
      hf_s2_q <= hf_s1_q;
      hf_s3_q <= hf_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_b2_q   <= '0;
      cap_b3_q   <= '0;
      samp_q     <= '0;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (cap_en) begin
        cap_b2_q <= buffer_2;
        cap_b3_q <= buffer_3;
        samp_q   <= reff;
      end
      if (upd_en) begin
        acc_q    <= acc_d;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (!win_full) fill_cnt_q <= fill_cnt_q + 1'b1;
      end
    end
  end

  // Ring contents survive reset; fill_cnt masks stale entries.
  always_ff @(posedge clk) begin
    if (upd_en) ring_q[wr_ptr_q] <= samp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch1_q        <= '0;
      ch2_q        <= '0;
      avg_q        <= '0;
      avg_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dev_flag_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= out_en;
      avg_valid_q  <= out_en & win_full;
      if (out_en) begin
        ch1_q       <= cap_b2_q;
        ch2_q       <= cap_b3_q;
        avg_q       <= avg_w;
        dev_flag_q  <= (abs_w > Thr);
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign ch1_out    = ch1_q;
  assign ch2_out    = ch2_q;
  assign avg_out    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign frame_done = frame_done_q;
  assign dev_flag   = dev_flag_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
